// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter_nbit family.
package counter_pkg;

   localparam int unsigned CNT_W_DEF = 16;

   // Next-state select for the count register.
   typedef enum logic [1:0] {
      CNT_HOLD  = 2'd0,
      CNT_LOAD  = 2'd1,
      CNT_STEP  = 2'd2,
      CNT_BOUND = 2'd3
   } cnt_op_t;

   // Behaviour of the count at a boundary event.
   typedef enum logic {
      BND_WRAP = 1'b0,
      BND_SAT  = 1'b1
   } bnd_mode_t;

endpackage : counter_pkg

// File: rtl/incdec_nbit.sv
// Combinational incrementer/decrementer built from half-adder ripple chains,
// plus the zero and limit compares the counter needs for boundary decode.
module incdec_nbit
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_W_DEF
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] inc_c,
   output logic [WIDTH-1:0] dec_c,
   output logic             is_zero_c,
   output logic             ge_limit_c
);

   // Half-adder chain: carry-in of 1 gives count+1, borrow-in of 1 gives count-1.
   always_comb begin
      logic carry;
      logic borrow;
      carry  = 1'b1;
      borrow = 1'b1;
      inc_c  = '0;
      dec_c  = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         inc_c[i] = count[i] ^ carry;
         carry    = count[i] & carry;
         dec_c[i] = count[i] ^ borrow;
         borrow   = ~count[i] & borrow;
      end
   end

   // Compares used to detect the up and down boundaries.
   always_comb begin
      is_zero_c  = (count == '0);
      ge_limit_c = (count >= limit);
   end

endmodule : incdec_nbit

// File: rtl/counter_nbit.sv
// Parametrised up/down counter with enable, parallel load, runtime modulo
// limit, terminal-count pulse and sticky overflow flag.
// Build option: define COUNTER_NBIT_SAT_EN to saturate at the boundary
// instead of wrapping; the port list is identical in both builds.
module counter_nbit
   import counter_pkg::*;
#(
   parameter int unsigned     WIDTH   = CNT_W_DEF,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

`ifdef COUNTER_NBIT_SAT_EN
   localparam bnd_mode_t BND_MODE = BND_SAT;
`else
   localparam bnd_mode_t BND_MODE = BND_WRAP;
`endif

   logic [WIDTH-1:0] inc_val;
   logic [WIDTH-1:0] dec_val;
   logic             is_zero;
   logic             ge_limit;

   cnt_op_t          op;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   logic             ovf_nxt;

   incdec_nbit #(
      .WIDTH (WIDTH)
   ) u_incdec (
      .count      (count),
      .limit      (limit),
      .inc_c      (inc_val),
      .dec_c      (dec_val),
      .is_zero_c  (is_zero),
      .ge_limit_c (ge_limit)
   );

   // Operation decode: load beats enable; an enabled step at the edge of the
   // range becomes a boundary event (count above limit counts as the edge).
   always_comb begin
      op = CNT_HOLD;
      if (load) begin
         op = CNT_LOAD;
      end else if (en) begin
         if (up) begin
            op = ge_limit ? CNT_BOUND : CNT_STEP;
         end else begin
            op = is_zero ? CNT_BOUND : CNT_STEP;
         end
      end
   end

   // Next-state mux for count, terminal count and overflow.
   always_comb begin
      count_nxt = count;
      tc_nxt    = 1'b0;
      ovf_nxt   = ovf;
      unique case (op)
         CNT_LOAD: begin
            count_nxt = load_val;
            ovf_nxt   = 1'b0;
         end
         CNT_STEP: begin
            count_nxt = up ? inc_val : dec_val;
         end
         CNT_BOUND: begin
            tc_nxt  = 1'b1;
            ovf_nxt = 1'b1;
            if (BND_MODE == BND_SAT) begin
               count_nxt = up ? limit : '0;
            end else begin
               count_nxt = up ? '0 : limit;
            end
         end
         default: begin
            count_nxt = count;
         end
      endcase
   end

   // Output registers; reset clears any pending terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= RST_VAL;
         tc    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= tc_nxt;
         ovf   <= ovf_nxt;
      end
   end

endmodule : counter_nbit

// File: tb/tb_counter_nbit.sv
// Self-checking bench for counter_nbit (WIDTH=8, RST_VAL=0).
// Honours COUNTER_NBIT_SAT_EN so the same bench covers both build modes.
module tb_counter_nbit;

   localparam int unsigned W = 8;

`ifdef COUNTER_NBIT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] count;
      logic         tc;
      logic         ovf;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] limit;
   logic [W-1:0] count;
   logic         tc;
   logic         ovf;

   exp_t mdl;
   exp_t sb[$];
   exp_t e;
   int   checks;
   int   failures;

   counter_nbit #(
      .WIDTH   (W),
      .RST_VAL (8'h00)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .limit    (limit),
      .count    (count),
      .tc       (tc),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour of one clock edge.
   function automatic exp_t model(exp_t s, logic ld, logic en_i, logic up_i,
                                  logic [W-1:0] lv, logic [W-1:0] lim);
      exp_t n;
      n = s;
      n.tc = 1'b0;
      if (ld) begin
         n.count = lv;
         n.ovf   = 1'b0;
      end else if (en_i) begin
         if (up_i) begin
            if (s.count >= lim) begin
               n.count = SAT ? lim : 8'h00;
               n.tc    = 1'b1;
               n.ovf   = 1'b1;
            end else begin
               n.count = W'(s.count + 8'd1);
            end
         end else begin
            if (s.count == 8'h00) begin
               n.count = SAT ? 8'h00 : lim;
               n.tc    = 1'b1;
               n.ovf   = 1'b1;
            end else begin
               n.count = W'(s.count - 8'd1);
            end
         end
      end
      return n;
   endfunction

   // Apply inputs for one edge, push the expected result, then advance.
   task automatic drive(input logic ld, input logic en_i, input logic up_i,
                        input logic [W-1:0] lv, input logic [W-1:0] lim);
      load     = ld;
      en       = en_i;
      up       = up_i;
      load_val = lv;
      limit    = lim;
      mdl      = model(mdl, ld, en_i, up_i, lv, lim);
      sb.push_back(mdl);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({count, tc, ovf} !== {8'h00, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_init: got count=%h tc=%b ovf=%b want 00 0 0", count, tc, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mdl   = '0;
      drive(1'b1, 1'b0, 1'b1, 8'h35, 8'hFF);
      e = sb.pop_front();
      checks++;
      if ({count, tc, ovf} !== e) begin
         failures++;
         $display("FAIL reset_preload: got %h %b %b want %h %b %b", count, tc, ovf, e.count, e.tc, e.ovf);
      end
      // Assert reset between edges and check without any clock.
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({count, tc, ovf} !== {8'h00, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_async: got count=%h tc=%b ovf=%b want 00 0 0", count, tc, ovf);
      end
      mdl = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_wrap_up();
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b1, 1'b1, 8'h00, 8'd9);
         e = sb.pop_front();
         checks++;
         if ({count, tc, ovf} !== e) begin
            failures++;
            $display("FAIL wrap_up[%0d]: got %h %b %b want %h %b %b", i, count, tc, ovf, e.count, e.tc, e.ovf);
         end
      end
      checks++;
      if ({count, ovf} !== {(SAT ? 8'd9 : 8'd2), 1'b1}) begin
         failures++;
         $display("FAIL wrap_up_end: got count=%h ovf=%b want %h 1", count, ovf, SAT ? 8'd9 : 8'd2);
      end
   endtask

   task automatic test_down_wrap();
      drive(1'b1, 1'b0, 1'b0, 8'h02, 8'h05);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h05);
      for (int i = 0; i < 5; i++) begin
         e = sb.pop_front();
         checks++;
         // Outputs already moved on; compare against the last pushed entry only.
         if (i == 4 && {count, tc, ovf} !== e) begin
            failures++;
            $display("FAIL down_wrap_end: got %h %b %b want %h %b %b", count, tc, ovf, e.count, e.tc, e.ovf);
         end
      end
      // Replay stepwise so every cycle is compared against the live outputs.
      drive(1'b1, 1'b0, 1'b0, 8'h02, 8'h05);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h05);
         e = sb.pop_front();
         checks++;
         if ({count, tc, ovf} !== e) begin
            failures++;
            $display("FAIL down_wrap[%0d]: got %h %b %b want %h %b %b", i, count, tc, ovf, e.count, e.tc, e.ovf);
         end
      end
   endtask

   task automatic test_priority();
      drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h05);
      drive(1'b1, 1'b1, 1'b1, 8'h7F, 8'h05);
      for (int i = 0; i < 2; i++) begin
         e = sb.pop_front();
         if (i == 1) begin
            checks++;
            if ({count, tc, ovf} !== {8'h7F, 1'b0, 1'b0} || e !== {8'h7F, 1'b0, 1'b0}) begin
               failures++;
               $display("FAIL priority: got %h %b %b want 7f 0 0", count, tc, ovf);
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      drive(1'b1, 1'b0, 1'b1, 8'hF0, 8'h10);
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h10);
         e = sb.pop_front();
         checks++;
         if ({count, tc, ovf} !== e) begin
            failures++;
            $display("FAIL out_of_range[%0d]: got %h %b %b want %h %b %b", i, count, tc, ovf, e.count, e.tc, e.ovf);
         end
      end
   endtask

   task automatic test_full_width();
      drive(1'b1, 1'b0, 1'b1, 8'hFE, 8'hFF);
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
         e = sb.pop_front();
         checks++;
         if ({count, tc, ovf} !== e) begin
            failures++;
            $display("FAIL full_width[%0d]: got %h %b %b want %h %b %b", i, count, tc, ovf, e.count, e.tc, e.ovf);
         end
      end
   endtask

   task automatic test_limit_zero();
      drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, (i < 2), 8'h00, 8'h00);
         e = sb.pop_front();
         checks++;
         if ({count, tc, ovf} !== e) begin
            failures++;
            $display("FAIL limit_zero[%0d]: got %h %b %b want %h %b %b", i, count, tc, ovf, e.count, e.tc, e.ovf);
         end
      end
      // Idle cycle: tc must drop, ovf must hold.
      drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      e = sb.pop_front();
      checks++;
      if ({count, tc, ovf} !== e) begin
         failures++;
         $display("FAIL hold: got %h %b %b want %h %b %b", count, tc, ovf, e.count, e.tc, e.ovf);
      end
   endtask

   task automatic test_back_to_back();
      logic         ld;
      logic         en_i;
      logic         up_i;
      logic [W-1:0] lv;
      logic [W-1:0] lim;
      lim = 8'd20;
      for (int i = 0; i < 300; i++) begin
         ld   = ($urandom_range(0, 15) == 0);
         en_i = ($urandom_range(0, 3) != 0);
         up_i = ($urandom_range(0, 2) != 0);
         lv   = W'($urandom_range(0, 255));
         if ($urandom_range(0, 31) == 0) lim = W'($urandom_range(0, 40));
         drive(ld, en_i, up_i, lv, lim);
         e = sb.pop_front();
         checks++;
         if ({count, tc, ovf} !== e) begin
            failures++;
            $display("FAIL b2b[%0d]: got %h %b %b want %h %b %b", i, count, tc, ovf, e.count, e.tc, e.ovf);
         end
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: got %0d entries want 0", sb.size());
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      up       = 1'b1;
      load     = 1'b0;
      load_val = '0;
      limit    = 8'hFF;
      mdl      = '0;
      #12;
      test_reset();
      test_wrap_up();
      test_down_wrap();
      test_priority();
      test_out_of_range();
      test_full_width();
      test_limit_zero();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_counter_nbit
